freelist: RTL and testbench

- Physical-register free list for the rename stage.
- Supplies up to two new physical destination registers per cycle to rename; those values are what rename writes into the rename table.
- Recycles old destination registers freed at commit.
- On a redirect, restores the speculative allocation pointer to the committed one.
- Circular 32-entry queue covering physical registers 32..63; physical registers 0..31 are the reset mappings of x0..x31.

---
 rtl/freelist.sv | 103 ++++++++++
 tb/tb_freelist.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/freelist.sv
// Physical-register free list for rename: a 32-entry circular queue of pregs 32..63 with
// speculative/committed heads. Optional checker enabled by TRINITY_FREELIST_CHECK_EN.
module freelist (
    input  logic       clock,
    input  logic       reset,
    input  logic       instr0_alloc_valid,
    input  logic       instr1_alloc_valid,
    output logic       alloc_ready,
    output logic [5:0] instr0_alloc_preg,
    output logic [5:0] instr1_alloc_preg,
    input  logic       commit0_valid,
    input  logic [5:0] commit0_free_preg,
    input  logic       commit1_valid,
    input  logic [5:0] commit1_free_preg,
    input  logic       redirect_valid,
    output logic [5:0] free_count,
    output logic       freelist_err
);
    localparam int ENTRIES = 32;

    logic [5:0] entries [ENTRIES];
    logic [5:0] spec_head;
    logic [5:0] arch_head;
    logic [5:0] tail;

    logic       alloc_fire;
    logic [1:0] n_alloc;
    logic [1:0] n_commit;
    logic [4:0] spec_idx1;
    logic [4:0] commit1_idx;
    logic [5:0] tail_next;
    logic [5:0] arch_head_next;
    logic [5:0] spec_head_next;

    assign free_count  = tail - spec_head;
    assign alloc_ready = (free_count >= 6'd2);
    assign alloc_fire  = alloc_ready & ~redirect_valid;

    assign n_alloc  = alloc_fire ? ({1'b0, instr0_alloc_valid} + {1'b0, instr1_alloc_valid}) : 2'd0;
    assign n_commit = {1'b0, commit0_valid} + {1'b0, commit1_valid};

    // instr1 takes the head entry itself when instr0 does not allocate
    assign spec_idx1         = spec_head[4:0] + 5'd1;
    assign instr0_alloc_preg = entries[spec_head[4:0]];
    assign instr1_alloc_preg = instr0_alloc_valid ? entries[spec_idx1] : entries[spec_head[4:0]];

    assign commit1_idx    = tail[4:0] + {4'b0, commit0_valid};
    assign tail_next      = tail + {4'b0, n_commit};
    assign arch_head_next = arch_head + {4'b0, n_commit};
    assign spec_head_next = redirect_valid ? arch_head_next : (spec_head + {4'b0, n_alloc});

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries[i] <= 6'(ENTRIES + i);
            end
            spec_head <= 6'b000000;
            arch_head <= 6'b000000;
            tail      <= 6'b100000;
        end else begin
            if (commit0_valid) begin
                entries[tail[4:0]] <= commit0_free_preg;
            end
            if (commit1_valid) begin
                entries[commit1_idx] <= commit1_free_preg;
            end
            spec_head <= spec_head_next;
            arch_head <= arch_head_next;
            tail      <= tail_next;
        end
    end

`ifdef TRINITY_FREELIST_CHECK_EN
    logic       err;
    logic [6:0] free_after;
    logic [6:0] cap_after;
    logic [5:0] spec_lead;
    logic       overflow;
    logic       bad_alloc;
    logic       arch_passed;

    // Free entries may never exceed the queue capacity once frees land
    assign free_after  = {1'b0, free_count} + {5'b0, n_commit};
    assign cap_after   = 7'd32 + {5'b0, n_alloc};
    assign overflow    = (free_after > cap_after);
    assign bad_alloc   = (instr0_alloc_valid | instr1_alloc_valid) & ~alloc_ready & ~redirect_valid;
    assign spec_lead   = (spec_head + {4'b0, n_alloc}) - arch_head_next;
    assign arch_passed = spec_lead[5] & (spec_lead[4:0] != 5'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            err <= 1'b0;
        end else if (overflow | bad_alloc | arch_passed) begin
            err <= 1'b1;
        end
    end

    assign freelist_err = err;
`else
    assign freelist_err = 1'b0;
`endif

endmodule

// File: tb/tb_freelist.sv
// Bench for freelist: directed scenarios plus randomized traffic against a queue-based
// reference model of the committed free-list order and the count of in-flight allocations.
module tb_freelist;
    logic       clock;
    logic       reset;
    logic       instr0_alloc_valid;
    logic       instr1_alloc_valid;
    logic       alloc_ready;
    logic [5:0] instr0_alloc_preg;
    logic [5:0] instr1_alloc_preg;
    logic       commit0_valid;
    logic [5:0] commit0_free_preg;
    logic       commit1_valid;
    logic [5:0] commit1_free_preg;
    logic       redirect_valid;
    logic [5:0] free_count;
    logic       freelist_err;

    int checks = 0;
    int errors = 0;

    // Reference model: fl holds the free list in committed order (oldest first),
    // inflight is the number of speculatively allocated, uncommitted entries.
    logic [5:0] fl[$];
    int         inflight;
    bit         m_err;

    freelist dut (
        .clock              (clock),
        .reset              (reset),
        .instr0_alloc_valid (instr0_alloc_valid),
        .instr1_alloc_valid (instr1_alloc_valid),
        .alloc_ready        (alloc_ready),
        .instr0_alloc_preg  (instr0_alloc_preg),
        .instr1_alloc_preg  (instr1_alloc_preg),
        .commit0_valid      (commit0_valid),
        .commit0_free_preg  (commit0_free_preg),
        .commit1_valid      (commit1_valid),
        .commit1_free_preg  (commit1_free_preg),
        .redirect_valid     (redirect_valid),
        .free_count         (free_count),
        .freelist_err       (freelist_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fl.delete();
        for (int i = 0; i < 32; i++) fl.push_back(6'(32 + i));
        inflight = 0;
        m_err    = 1'b0;
    endtask

    // Reset is held together with junk on every other input; reset must win.
    task automatic do_reset();
        reset              = 1'b1;
        instr0_alloc_valid = 1'b1;
        instr1_alloc_valid = 1'b1;
        commit0_valid      = 1'b1;
        commit0_free_preg  = 6'd9;
        commit1_valid      = 1'b1;
        commit1_free_preg  = 6'd10;
        redirect_valid     = 1'b1;
        @(posedge clock);
        #1;
        reset              = 1'b0;
        instr0_alloc_valid = 1'b0;
        instr1_alloc_valid = 1'b0;
        commit0_valid      = 1'b0;
        commit1_valid      = 1'b0;
        redirect_valid     = 1'b0;
        model_reset();
    endtask

    // One clock: drive inputs, check outputs mid-cycle against the model, advance the model.
    task automatic step(input bit v0, input bit v1, input bit c0, input logic [5:0] p0,
                        input bit c1, input logic [5:0] p1, input bit rd);
        int fc, na, nc;
        bit rdy;
        logic [5:0] e0, e1;
        instr0_alloc_valid = v0;
        instr1_alloc_valid = v1;
        commit0_valid      = c0;
        commit0_free_preg  = p0;
        commit1_valid      = c1;
        commit1_free_preg  = p1;
        redirect_valid     = rd;
        @(negedge clock);
        fc  = 32 - inflight;
        rdy = (fc >= 2);
        e0  = fl[inflight % 32];
        e1  = v0 ? fl[(inflight + 1) % 32] : fl[inflight % 32];
        chk("free_count", 32'(free_count), 32'(fc));
        chk("alloc_ready", 32'(alloc_ready), 32'(rdy));
        chk("instr0_preg", 32'(instr0_alloc_preg), 32'(e0));
        chk("instr1_preg", 32'(instr1_alloc_preg), 32'(e1));
        chk("freelist_err", 32'(freelist_err), 32'(m_err));
`ifdef TRINITY_FREELIST_CHECK_EN
        if ((v0 || v1) && !rdy && !rd) m_err = 1'b1;
`endif
        na = (rdy && !rd) ? (int'(v0) + int'(v1)) : 0;
        nc = int'(c0) + int'(c1);
        for (int i = 0; i < nc; i++) void'(fl.pop_front());
        if (c0) fl.push_back(p0);
        if (c1) fl.push_back(p1);
        inflight = inflight + na - nc;
        if (rd) inflight = 0;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        instr0_alloc_valid = 1'b0;
        instr1_alloc_valid = 1'b0;
        commit0_valid = 1'b0;
        commit0_free_preg = 6'd0;
        commit1_valid = 1'b0;
        commit1_free_preg = 6'd0;
        redirect_valid = 1'b0;
        @(posedge clock);
        #1;

        // Pair allocation from reset: 32,33 then 34,35 with 30 free
        do_reset();
        step(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        idle();
        chk("t1_free_count", 32'(free_count), 32'd30);
        chk("t1_preg0", 32'(instr0_alloc_preg), 32'd34);

        // instr1-only allocation takes the head entry
        do_reset();
        step(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        chk("t2_free_count", 32'(free_count), 32'd30);

        // Drain completely, then two commits refill exactly two entries
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        idle();
        chk("t3_empty_ready", 32'(alloc_ready), 32'd0);
        step(1'b0, 1'b0, 1'b1, 6'd5, 1'b1, 6'd7, 1'b0);
        chk("t3_refill_ready", 32'(alloc_ready), 32'd1);
        chk("t3_refill_p0", 32'(instr0_alloc_preg), 32'd5);
        chk("t3_refill_p1_pre", 32'(instr1_alloc_preg), 32'd5);
        step(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        idle();

        // Allocate 6, commit 2, redirect: next allocation is 34
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 6'd1, 1'b1, 6'd2, 1'b0);
        step(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1);
        chk("t4_redirect_p0", 32'(instr0_alloc_preg), 32'd34);
        step(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);

        // Redirect with simultaneous allocs and commits
        step(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 6'd20, 1'b1, 6'd21, 1'b1);
        step(1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 6'd22, 1'b0);
        idle();

        // Randomized traffic; commits never exceed the in-flight allocations
        do_reset();
        for (int n = 0; n < 400; n++) begin
            bit v0, v1, c0, c1, rd;
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            rd = ($urandom_range(0, 15) == 0);
            c0 = 1'b0;
            c1 = 1'b0;
            if (inflight >= 2) begin
                c0 = 1'($urandom_range(0, 1));
                c1 = 1'($urandom_range(0, 1));
            end else if (inflight == 1) begin
                c1 = 1'($urandom_range(0, 1));
            end
            `ifndef TRINITY_FREELIST_CHECK_EN
            `else
            if (inflight > 30) begin
                v0 = 1'b0;
                v1 = 1'b0;
            end
            `endif
            step(v0, v1, c0, 6'($urandom_range(0, 63)), c1, 6'($urandom_range(0, 63)), rd);
            if (n == 200) do_reset();
        end
        idle();

        // Over-freeing commit from the reset image
        do_reset();
        commit0_valid     = 1'b1;
        commit0_free_preg = 6'd3;
        @(posedge clock);
        #1;
        commit0_valid = 1'b0;
`ifdef TRINITY_FREELIST_CHECK_EN
        chk("t6_err_set", 32'(freelist_err), 32'd1);
        @(posedge clock);
        #1;
        chk("t6_err_sticky", 32'(freelist_err), 32'd1);
`else
        chk("t6_err_set", 32'(freelist_err), 32'd0);
        @(posedge clock);
        #1;
        chk("t6_err_sticky", 32'(freelist_err), 32'd0);
`endif
        do_reset();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
